mem_responder: RTL

// - Memory-side responder for the core's multicycle fetch/load/store port.
// - Accepts one request at a time (instruction fetch, data load, or data store) on a valid/ready channel.
// - Services it from an internal word RAM after a fixed, configurable latency.
// - Returns read data and an error flag on a response channel, held until the core accepts it.

---
 rtl/mem_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the core's multicycle fetch/load/store port.
// Accepts one request at a time on a valid/ready channel, services it from an internal
// word RAM after LATENCY cycles, and holds the response until the core accepts it.
//
// Optional feature: define MEM_RESP_MISALIGN_ERR_EN to fault accesses with addr[1:0] != 0.
// Without it, the low address bits are ignored and the containing aligned word is used.
//
// Ports:
//   clk_i        clock, all logic on posedge
//   reset_i      synchronous active-high reset
//   req_valid_i  request present            req_ready_o  request can be accepted
//   req_we_i     1 = store, 0 = load/fetch  req_addr_i   byte address
//   req_wdata_i  store data                 req_be_i     store byte enables
//   rsp_valid_o  response present           rsp_ready_i  core accepts the response
//   rsp_rdata_o  load data (0 on store/err) rsp_err_o    access faulted, RAM untouched
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IdxW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp;
  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata, acc_off, acc_word;
  logic [3:0]  acc_be;
  logic        range_err, misalign_err, acc_err;
  logic [IdxW-1:0] acc_idx;

  assign req_ready_o = (state_q == StIdle) && !reset_i;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY <= 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = LatM1;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // With LATENCY=1 the RESP entry coincides with acceptance, so the request fields are not
  // latched yet and must come straight from the inputs.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = req_we_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_be    = req_be_i;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign acc_off   = acc_addr - BASE_ADDR;
  assign acc_word  = acc_off >> 2;
  assign range_err = (acc_addr < BASE_ADDR) || (acc_word >= 32'(DEPTH_WORDS));
  assign acc_idx   = acc_word[IdxW-1:0];
`ifdef MEM_RESP_MISALIGN_ERR_EN
  assign misalign_err = |acc_addr[1:0];
`else
  assign misalign_err = 1'b0;
`endif
  assign acc_err = range_err || misalign_err;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
      end else if (rsp_valid_o && rsp_ready_i) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // RAM is not reset; a store commits only on the RESP-entry edge, so a reset in BUSY drops it.
  always_ff @(posedge clk_i) begin
    if (!reset_i && enter_resp && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule
